mq_linked_buffer_1k1l: RTL and testbench
========================================

Name: mq_linked_buffer_1k1l

Overview:
- Multi-queue packet buffer: NUMQUEU logical FIFOs share one pool of NUMCELL data cells.
- Each queue is a linked list (head/tail/count). Free cells are tracked in a free-index FIFO.
- One push port and one pop port. Pop data returns after a fixed DELAY-cycle latency with a valid strobe.
- This is the responder side of the push/pop/freecnt/ready queue interface driven by the 1k1l_a402 bench.

Parameters:
- WIDTH, 8: data width per cell
- NUMQUEU, 64: number of logical queues
- BITQUEU, 6: queue address width, clog2(NUMQUEU)
- NUMCELL, 48: shared cell pool size
- BITCELL, 6: cell index width, clog2(NUMCELL)
- DEPTH, 32: per-queue occupancy cap
- BITADDR, 5: clog2(DEPTH); per-queue count is BITADDR+1 bits
- BITQCNT, 6: freecnt width; NUMCELL <= 2**BITQCNT-1 is required
- DELAY, 4: pop-to-data latency in cycles; must be >= 1

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high once free-list initialisation is complete
- push  in  1  push request
- pu_adr  in  BITQUEU  target queue for push
- pu_din  in  WIDTH  push data
- pop  in  1  pop request
- po_adr  in  BITQUEU  target queue for pop
- po_dvld  out  1  pop data valid
- po_dout  out  WIDTH  pop data
- freecnt  out  BITQCNT  number of unallocated cells

Behaviour:
- Reset (rst=1 sampled at the rising edge):
  - ready=0, po_dvld=0, po_dout=0, freecnt=0.
  - All queue counts = 0; head/tail = 0; delay pipeline cleared; free FIFO empty.
  - Reset asserted mid-operation discards all queued data and in-flight pops. No po_dvld fires after reset.
- INIT state (first cycle with rst=0):
  - Writes cell index i into free FIFO slot i, one per cycle, i = 0..NUMCELL-1.
  - freecnt increments by 1 per cycle.
  - After NUMCELL cycles the block moves to RUN and ready=1, with freecnt=NUMCELL.
  - push/pop are ignored while ready=0.
- RUN state; stays here until rst.
- Push is accepted when push & ready & freecnt>0 & count[pu_adr]<DEPTH. Otherwise it is silently dropped with no state change.
  - On accept: allocate cell c = free FIFO head, then write data[c]=pu_din.
  - If the queue is empty: head=tail=c. Otherwise: next[tail]=c, then tail=c.
  - count[pu_adr] increments.
- Pop is accepted when pop & ready & count[po_adr]>0, using the count before this cycle's push.
  - A pop of an empty queue is ignored and produces no po_dvld. This applies even if the same queue is pushed in the same cycle.
  - On accept: capture data[head] into the delay pipeline; head=next[head]; count decrements; the freed cell index is pushed to the free FIFO tail.
  - A freed cell is allocatable from the next cycle, never the same cycle.
- Simultaneous push and pop:
  - Different queues: both proceed independently.
  - Same queue with count=1: the pop returns the old head; head=tail=new cell; count stays 1.
  - freecnt is unchanged when both are accepted; +1 on pop only; -1 on push only.
- Latency: a pop accepted at edge k gives po_dvld=1 and po_dout=data during the cycle after edge k+DELAY-1, i.e. exactly DELAY cycles later.
  - Back-to-back pops give back-to-back po_dvld.
  - po_dout holds its last value when po_dvld=0.
- Ordering: data pops out of each queue in strict push order. The pool wraps freely; cell indices recycle in free-FIFO order.
- Invariant: freecnt + sum(count[q]) == NUMCELL at all times in RUN.

Test Plan:
- rst 20 cycles then release → ready=0 for exactly 48 cycles, then 1; freecnt reads 48 at ready rise; po_dvld=0 throughout.
- Push 0xA1, 0xA2, 0xA3 to queue 5, then 3 pops of queue 5 → po_dvld 4 cycles after each pop with 0xA1, 0xA2, 0xA3; freecnt goes 45 → 48.
- Push 48 values round-robin over queues 0..47, then a 49th push to queue 0 → 49th push dropped; freecnt=0. One pop of queue 0 → freecnt=1 and the next push is accepted.
- Queue 3 holds 1 entry (0x11); same cycle push queue 3 (0x22) and pop queue 3 → po_dout=0x11 after 4 cycles; count[3]=1; freecnt unchanged; next pop returns 0x22.
- Pop of empty queue 9, and pop of queue 9 coincident with its first push → no po_dvld; the pushed value remains and pops later.
- 20000 random cycles (75% push, 75% pop, random queues) with reset asserted once mid-run → per-queue FIFO order matches the model; freecnt invariant holds; no po_dvld for pops issued before the reset.

Source files
------------

// File: rtl/mq_linked_buffer_1k1l.sv
// Multi-queue packet buffer: NUMQUEU linked-list FIFOs sharing a NUMCELL cell pool,
// with a free-index FIFO for allocation and a fixed DELAY-cycle pop data pipeline.
module mq_linked_buffer_1k1l #(
  parameter int WIDTH   = 8,
  parameter int NUMQUEU = 64,
  parameter int BITQUEU = 6,
  parameter int NUMCELL = 48,
  parameter int BITCELL = 6,
  parameter int DEPTH   = 32,
  parameter int BITADDR = 5,
  parameter int BITQCNT = 6,
  parameter int DELAY   = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               push,
  input  logic [BITQUEU-1:0] pu_adr,
  input  logic [WIDTH-1:0]   pu_din,
  input  logic               pop,
  input  logic [BITQUEU-1:0] po_adr,
  output logic               po_dvld,
  output logic [WIDTH-1:0]   po_dout,
  output logic [BITQCNT-1:0] freecnt
);

  localparam logic [BITADDR:0]   CAP  = (BITADDR+1)'(DEPTH);
  localparam logic [BITADDR:0]   ONE  = (BITADDR+1)'(1);
  localparam logic [BITCELL-1:0] LAST = BITCELL'(NUMCELL-1);

  typedef enum logic {S_INIT, S_RUN} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0]   mem      [NUMCELL];
  logic [BITCELL-1:0] nxt      [NUMCELL];
  logic [BITCELL-1:0] free_mem [NUMCELL];
  logic [BITCELL-1:0] head     [NUMQUEU];
  logic [BITCELL-1:0] tail     [NUMQUEU];
  logic [BITADDR:0]   cnt      [NUMQUEU];
  logic [BITCELL-1:0] frd, fwr;

  logic               push_ok, pop_ok, same_q;
  logic [BITCELL-1:0] alloc, freed;
  logic [WIDTH-1:0]   rd_data;

  logic [DELAY-1:0]   vld_pipe;
  logic [WIDTH-1:0]   dat_pipe [DELAY];

  function automatic logic [BITCELL-1:0] wrap_inc(input logic [BITCELL-1:0] p);
    return (p == LAST) ? '0 : p + BITCELL'(1);
  endfunction

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && fwr == LAST) state_nxt = S_RUN;
  end

  always_comb begin
    ready = (state == S_RUN);
  end

  assign alloc   = free_mem[frd];
  assign freed   = head[po_adr];
  assign rd_data = mem[freed];

  // Both acceptance tests use pre-cycle counts, so a pop never sees a same-cycle push.
  assign push_ok = push & ready & (freecnt != '0) & (cnt[pu_adr] < CAP);
  assign pop_ok  = pop & ready & (cnt[po_adr] != '0);
  assign same_q  = push_ok & pop_ok & (pu_adr == po_adr);

  always_ff @(posedge clk) begin
    if (rst) begin
      frd     <= '0;
      fwr     <= '0;
      freecnt <= '0;
      for (int q = 0; q < NUMQUEU; q++) begin
        cnt[q]  <= '0;
        head[q] <= '0;
        tail[q] <= '0;
      end
    end else if (state == S_INIT) begin
      fwr     <= wrap_inc(fwr);
      freecnt <= freecnt + BITQCNT'(1);
    end else begin
      if (push_ok) frd <= wrap_inc(frd);
      if (pop_ok)  fwr <= wrap_inc(fwr);
      case ({push_ok, pop_ok})
        2'b10:   freecnt <= freecnt - BITQCNT'(1);
        2'b01:   freecnt <= freecnt + BITQCNT'(1);
        default: freecnt <= freecnt;
      endcase
      if (push_ok) begin
        if (cnt[pu_adr] == '0) head[pu_adr] <= alloc;
        tail[pu_adr] <= alloc;
      end
      // With one entry and a same-queue push, next[head] is written this edge: bypass it.
      if (pop_ok)
        head[po_adr] <= (same_q && cnt[po_adr] == ONE) ? alloc : nxt[freed];
      if (!same_q) begin
        if (push_ok) cnt[pu_adr] <= cnt[pu_adr] + ONE;
        if (pop_ok)  cnt[po_adr] <= cnt[po_adr] - ONE;
      end
    end
  end

  // Storage arrays carry no reset; the free list is rebuilt during INIT.
  always_ff @(posedge clk) begin
    if (state == S_INIT)  free_mem[fwr] <= fwr;
    else if (pop_ok)      free_mem[fwr] <= freed;
    if (push_ok) begin
      mem[alloc] <= pu_din;
      if (cnt[pu_adr] != '0) nxt[tail[pu_adr]] <= alloc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      dat_pipe[0] <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | DELAY'(pop_ok);
      if (pop_ok) dat_pipe[0] <= rd_data;
    end
  end

  // Stages load only behind a valid, so the last stage holds the last popped word.
  for (genvar g = 1; g < DELAY; g++) begin : g_stage
    always_ff @(posedge clk) begin
      if (rst)                dat_pipe[g] <= '0;
      else if (vld_pipe[g-1]) dat_pipe[g] <= dat_pipe[g-1];
    end
  end

  assign po_dvld = vld_pipe[DELAY-1];
  assign po_dout = dat_pipe[DELAY-1];

endmodule

// File: tb/tb_mq_linked_buffer_1k1l.sv
// Directed and random checks for the shared-pool multi-queue buffer.
module tb_mq_linked_buffer_1k1l;
  logic       clk = 1'b0, rst = 1'b1;
  logic       ready, push = 1'b0, pop = 1'b0, po_dvld;
  logic [5:0] pu_adr = '0, po_adr = '0, freecnt;
  logic [7:0] pu_din = '0, po_dout;

  int tests = 0, fails = 0, cyc = 0;

  typedef struct { int c; logic [7:0] d; } ev_t;
  ev_t obs[$];
  ev_t exq[$];

  mq_linked_buffer_1k1l dut (
    .clk(clk), .rst(rst), .ready(ready), .push(push), .pu_adr(pu_adr), .pu_din(pu_din),
    .pop(pop), .po_adr(po_adr), .po_dvld(po_dvld), .po_dout(po_dout), .freecnt(freecnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (po_dvld) obs.push_back('{cyc, po_dout});

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic p, input logic [5:0] pa, input logic [7:0] pd,
                       input logic o, input logic [5:0] oa);
    push = p; pu_adr = pa; pu_din = pd; pop = o; po_adr = oa;
    tick();
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (20) tick();
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b want 0", ready); end
    tests++; if (po_dvld !== 1'b0) begin fails++; $display("FAIL rst_dvld got %b want 0", po_dvld); end
    tests++; if (po_dout !== 8'h00) begin fails++; $display("FAIL rst_dout got %h want 00", po_dout); end
    tests++; if (freecnt !== 6'd0) begin fails++; $display("FAIL rst_freecnt got %0d want 0", freecnt); end
    rst = 1'b0;
    push = 1'b1; pu_adr = 6'd0; pu_din = 8'h5A; pop = 1'b1; po_adr = 6'd0;
    for (int n = 1; n <= 48; n++) begin
      tick();
      tests++;
      if (ready !== (n == 48)) begin fails++; $display("FAIL init_ready n=%0d got %b want %b", n, ready, n == 48); end
      tests++;
      if (freecnt !== 6'(n)) begin fails++; $display("FAIL init_freecnt n=%0d got %0d want %0d", n, freecnt, n); end
      tests++;
      if (po_dvld !== 1'b0) begin fails++; $display("FAIL init_dvld n=%0d got %b want 0", n, po_dvld); end
    end
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_fifo_order();
    int e[3];
    logic [7:0] want[3];
    want[0] = 8'hA1; want[1] = 8'hA2; want[2] = 8'hA3;
    obs.delete();
    for (int i = 0; i < 3; i++) drive(1'b1, 6'd5, want[i], 1'b0, 6'd0);
    tests++; if (freecnt !== 6'd45) begin fails++; $display("FAIL fifo_free45 got %0d want 45", freecnt); end
    for (int i = 0; i < 3; i++) begin drive(1'b0, 6'd0, 8'h00, 1'b1, 6'd5); e[i] = cyc; end
    repeat (5) tick();
    tests++;
    if (obs.size() !== 3) begin fails++; $display("FAIL fifo_count got %0d want 3", obs.size()); end
    else for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs[i].c !== e[i] + 3 || obs[i].d !== want[i]) begin
        fails++; $display("FAIL fifo_pop%0d got cyc %0d data %h want cyc %0d data %h", i, obs[i].c, obs[i].d, e[i] + 3, want[i]);
      end
    end
    tests++; if (freecnt !== 6'd48) begin fails++; $display("FAIL fifo_free48 got %0d want 48", freecnt); end
    tests++;
    if (po_dvld !== 1'b0 || po_dout !== 8'hA3) begin
      fails++; $display("FAIL fifo_hold got dvld %b dout %h want 0 a3", po_dvld, po_dout);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 48; i++) drive(1'b1, 6'(i), 8'(i), 1'b0, 6'd0);
    tests++; if (freecnt !== 6'd0) begin fails++; $display("FAIL full_free got %0d want 0", freecnt); end
    drive(1'b1, 6'd0, 8'hEE, 1'b0, 6'd0);
    tests++; if (freecnt !== 6'd0) begin fails++; $display("FAIL full_drop got %0d want 0", freecnt); end
    obs.delete();
    drive(1'b0, 6'd0, 8'h00, 1'b1, 6'd0);
    tests++; if (freecnt !== 6'd1) begin fails++; $display("FAIL full_pop_free got %0d want 1", freecnt); end
    drive(1'b1, 6'd0, 8'h77, 1'b0, 6'd0);
    tests++; if (freecnt !== 6'd0) begin fails++; $display("FAIL full_repush got %0d want 0", freecnt); end
    repeat (4) tick();
    tests++;
    if (obs.size() !== 1 || obs[0].d !== 8'h00) begin fails++; $display("FAIL full_first got n=%0d want 1 entry 00", obs.size()); end
    obs.delete();
    for (int q = 0; q < 48; q++) drive(1'b0, 6'd0, 8'h00, 1'b1, 6'(q));
    repeat (5) tick();
    tests++;
    if (obs.size() !== 48) begin fails++; $display("FAIL full_drain got %0d want 48", obs.size()); end
    else for (int q = 0; q < 48; q++) begin
      tests++;
      if (obs[q].d !== ((q == 0) ? 8'h77 : 8'(q))) begin
        fails++; $display("FAIL full_drain_q%0d got %h want %h", q, obs[q].d, (q == 0) ? 8'h77 : 8'(q));
      end
    end
    tests++; if (freecnt !== 6'd48) begin fails++; $display("FAIL full_refill got %0d want 48", freecnt); end
  endtask

  task automatic test_same_q();
    int e;
    drive(1'b1, 6'd3, 8'h11, 1'b0, 6'd0);
    tests++; if (freecnt !== 6'd47) begin fails++; $display("FAIL sameq_free0 got %0d want 47", freecnt); end
    obs.delete();
    drive(1'b1, 6'd3, 8'h22, 1'b1, 6'd3); e = cyc;
    tests++; if (freecnt !== 6'd47) begin fails++; $display("FAIL sameq_free1 got %0d want 47", freecnt); end
    repeat (4) tick();
    tests++;
    if (obs.size() !== 1 || obs[0].c !== e + 3 || obs[0].d !== 8'h11) begin
      fails++; $display("FAIL sameq_old got n=%0d want one 11 at cyc %0d", obs.size(), e + 3);
    end
    obs.delete();
    drive(1'b0, 6'd0, 8'h00, 1'b1, 6'd3);
    drive(1'b0, 6'd0, 8'h00, 1'b1, 6'd3);
    repeat (5) tick();
    tests++;
    if (obs.size() !== 1 || obs[0].d !== 8'h22) begin fails++; $display("FAIL sameq_new got n=%0d want one 22", obs.size()); end
    tests++; if (freecnt !== 6'd48) begin fails++; $display("FAIL sameq_free2 got %0d want 48", freecnt); end
  endtask

  task automatic test_empty_pop();
    obs.delete();
    drive(1'b0, 6'd0, 8'h00, 1'b1, 6'd9);
    drive(1'b1, 6'd9, 8'h99, 1'b1, 6'd9);
    repeat (5) tick();
    tests++; if (obs.size() !== 0) begin fails++; $display("FAIL empty_nodvld got %0d want 0", obs.size()); end
    tests++; if (freecnt !== 6'd47) begin fails++; $display("FAIL empty_free got %0d want 47", freecnt); end
    drive(1'b0, 6'd0, 8'h00, 1'b1, 6'd9);
    repeat (4) tick();
    tests++;
    if (obs.size() !== 1 || obs[0].d !== 8'h99) begin fails++; $display("FAIL empty_later got n=%0d want one 99", obs.size()); end
    tests++; if (freecnt !== 6'd48) begin fails++; $display("FAIL empty_free2 got %0d want 48", freecnt); end
  endtask

  task automatic test_random();
    logic [7:0] mq [64][$];
    int minit, mfree, rst_hold;
    logic p, o, pu_ok, po_ok;
    logic [5:0] pa, oa;
    logic [7:0] pd, pdat;
    ev_t ev, ex;
    minit = 48; mfree = 48; rst_hold = 0;
    obs.delete(); exq.delete();
    for (int it = 0; it < 20000; it++) begin
      if (it == 10000) rst_hold = 3;
      p  = (it < 19990) && ($urandom_range(0, 3) != 0);
      o  = (it < 19990) && ($urandom_range(0, 3) != 0);
      pa = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      oa = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      pd = 8'($urandom);
      if (rst_hold > 0) begin rst = 1'b1; rst_hold--; end else rst = 1'b0;
      push = p; pu_adr = pa; pu_din = pd; pop = o; po_adr = oa;
      tick();
      while (obs.size() > 0) begin
        ev = obs.pop_front();
        tests++;
        if (exq.size() == 0) begin
          fails++; $display("FAIL rnd_spurious cyc %0d data %h want no output", ev.c, ev.d);
        end else begin
          ex = exq.pop_front();
          if (ev.c !== ex.c || ev.d !== ex.d) begin
            fails++; $display("FAIL rnd_data got cyc %0d data %h want cyc %0d data %h", ev.c, ev.d, ex.c, ex.d);
          end
        end
      end
      if (exq.size() > 0 && exq[0].c < cyc) begin
        tests++; fails++;
        $display("FAIL rnd_missing want data %h at cyc %0d, got no output", exq[0].d, exq[0].c);
        void'(exq.pop_front());
      end
      if (rst) begin
        exq.delete();
        for (int q = 0; q < 64; q++) mq[q].delete();
        minit = 0; mfree = 0;
      end else if (minit < 48) begin
        minit++; mfree++;
      end else begin
        pu_ok = p && (mfree > 0) && (mq[pa].size() < 32);
        po_ok = o && (mq[oa].size() > 0);
        if (po_ok) begin
          pdat = mq[oa].pop_front();
          exq.push_back('{cyc + 3, pdat});
          mfree++;
        end
        if (pu_ok) begin
          mq[pa].push_back(pd);
          mfree--;
        end
      end
      tests++;
      if (freecnt !== 6'(mfree)) begin fails++; $display("FAIL rnd_freecnt it=%0d got %0d want %0d", it, freecnt, mfree); end
      tests++;
      if (ready !== (minit == 48)) begin fails++; $display("FAIL rnd_ready it=%0d got %b want %b", it, ready, minit == 48); end
    end
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    tests++;
    if (exq.size() !== 0) begin fails++; $display("FAIL rnd_leftover got %0d pending want 0", exq.size()); end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_full();
    test_same_q();
    test_empty_pop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
